// File: rtl/rv32im_muldiv_issue_pkg.sv
// Shared definitions for the M-extension issue block: op codes, FSM states
// and the signed-overflow / all-ones constants.
package rv32im_muldiv_issue_pkg;

   localparam int unsigned MD_XLEN = 32;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_WAIT  = 2'b10,
      ST_WB    = 2'b11
   } md_state_e;

   localparam logic [MD_XLEN-1:0] MD_SIGNED_MIN = {1'b1, {(MD_XLEN-1){1'b0}}};
   localparam logic [MD_XLEN-1:0] MD_ALL_ONES   = {MD_XLEN{1'b1}};

endpackage

// File: rtl/rv32im_muldiv_special.sv
// Combinational classifier for the divide corner cases that RISC-V defines
// without trapping: divide-by-zero and most-negative / -1 overflow.
module rv32im_muldiv_special
   import rv32im_muldiv_issue_pkg::*;
#(
   parameter int XLEN = MD_XLEN
) (
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            is_special,
   output logic [XLEN-1:0] special_result
);

   localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONES   = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] ZERO       = {XLEN{1'b0}};

   logic div_zero_s;
   logic overflow_s;

   assign div_zero_s = (rs2 == ZERO);
   assign overflow_s = (rs1 == SIGNED_MIN) && (rs2 == ALL_ONES);

   // Classify the op and select the architecturally defined result.
   always_comb begin
      is_special     = 1'b0;
      special_result = ZERO;
      case (funct3)
         OP_DIV: begin
            if (div_zero_s) begin
               is_special     = 1'b1;
               special_result = ALL_ONES;
            end else if (overflow_s) begin
               is_special     = 1'b1;
               special_result = SIGNED_MIN;
            end else begin
               is_special     = 1'b0;
            end
         end
         OP_DIVU: begin
            if (div_zero_s) begin
               is_special     = 1'b1;
               special_result = ALL_ONES;
            end else begin
               is_special     = 1'b0;
            end
         end
         OP_REM: begin
            if (div_zero_s) begin
               is_special     = 1'b1;
               special_result = rs1;
            end else if (overflow_s) begin
               is_special     = 1'b1;
               special_result = ZERO;
            end else begin
               is_special     = 1'b0;
            end
         end
         OP_REMU: begin
            if (div_zero_s) begin
               is_special     = 1'b1;
               special_result = rs1;
            end else begin
               is_special     = 1'b0;
            end
         end
         default: begin
            is_special     = 1'b0;
            special_result = ZERO;
         end
      endcase
   end

endmodule

// File: rtl/rv32im_muldiv_issue.sv
// Issue side of the M-extension muldiv interface: resolves corner cases and
// repeats locally, otherwise hands the op to the iterative unit.
module rv32im_muldiv_issue
   import rv32im_muldiv_issue_pkg::*;
#(
   parameter int XLEN         = MD_XLEN,
   parameter bit RESULT_CACHE = 1'b1
) (
   input  logic            clk_i,
   input  logic            clear_i,
   input  logic            flush_i,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [4:0]      rd_i,
   output logic            md_data_ready_o,
   output logic [2:0]      md_operation_o,
   output logic [XLEN-1:0] md_operand1_o,
   output logic [XLEN-1:0] md_operand2_o,
   output logic            md_writeback_ce_o,
   output logic            md_clear_o,
   input  logic [XLEN-1:0] md_result_i,
   input  logic            md_data_ready_i,
   input  logic            md_busy_i,
   output logic            wb_valid_o,
   input  logic            wb_ready_i,
   output logic [4:0]      wb_rd_o,
   output logic [XLEN-1:0] wb_data_o
);

   localparam logic [XLEN-1:0] ZERO = {XLEN{1'b0}};

   md_state_e       state_r, state_s;
   logic [2:0]      op_r, op_s;
   logic [XLEN-1:0] a_r, a_s, b_r, b_s;
   logic [4:0]      rd_r, rd_s;
   logic            wb_valid_r, wb_valid_s;
   logic [XLEN-1:0] wb_data_r, wb_data_s;
   logic            strobe_r, strobe_s;
   logic            ce_r, ce_s;
   logic            abort_r, abort_s;
   logic            guard_r;
   logic            cache_valid_r, cache_we_s;
   logic [2:0]      cache_op_r;
   logic [XLEN-1:0] cache_a_r, cache_b_r, cache_res_r;
   logic            accept_s, cache_hit_s, is_special_s, done_s;
   logic [XLEN-1:0] special_result_s;

   rv32im_muldiv_special #(.XLEN(XLEN)) u_special (
      .funct3         (funct3_i),
      .rs1            (rs1_i),
      .rs2            (rs2_i),
      .is_special     (is_special_s),
      .special_result (special_result_s)
   );

   assign ready_o     = (state_r == ST_IDLE);
   assign accept_s    = valid_i & ready_o & ~flush_i;
   assign cache_hit_s = RESULT_CACHE & cache_valid_r & (cache_op_r == funct3_i)
                        & (cache_a_r == rs1_i) & (cache_b_r == rs2_i);
   // The unit's flag is distrusted in the strobe cycle and the one after it.
   assign done_s      = md_data_ready_i & ~strobe_r & ~guard_r;

   // Next-state and next-output decode.
   always_comb begin
      state_s    = state_r;
      op_s       = op_r;
      a_s        = a_r;
      b_s        = b_r;
      rd_s       = rd_r;
      wb_valid_s = wb_valid_r;
      wb_data_s  = wb_data_r;
      strobe_s   = 1'b0;
      ce_s       = 1'b0;
      abort_s    = 1'b0;
      cache_we_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               op_s = funct3_i;
               a_s  = rs1_i;
               b_s  = rs2_i;
               rd_s = rd_i;
               if (rd_i == 5'd0) begin
                  state_s    = ST_WB;
                  wb_valid_s = 1'b0;
               end else if (is_special_s) begin
                  state_s    = ST_WB;
                  wb_valid_s = 1'b1;
                  wb_data_s  = special_result_s;
               end else if (cache_hit_s) begin
                  state_s    = ST_WB;
                  wb_valid_s = 1'b1;
                  wb_data_s  = cache_res_r;
               end else begin
                  state_s    = ST_ISSUE;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (flush_i) begin
               state_s = ST_IDLE;
               abort_s = 1'b1;
            end else if (!md_busy_i) begin
               state_s  = ST_WAIT;
               strobe_s = 1'b1;
            end else begin
               state_s = ST_ISSUE;
            end
         end
         ST_WAIT: begin
            if (flush_i) begin
               state_s = ST_IDLE;
               abort_s = 1'b1;
            end else if (done_s) begin
               state_s    = ST_WB;
               wb_valid_s = 1'b1;
               wb_data_s  = md_result_i;
               ce_s       = 1'b1;
               cache_we_s = 1'b1;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_WB: begin
            if (flush_i || wb_ready_i || !wb_valid_r) begin
               state_s    = ST_IDLE;
               wb_valid_s = 1'b0;
            end else begin
               state_s = ST_WB;
            end
         end
         default: begin
            state_s    = ST_IDLE;
            wb_valid_s = 1'b0;
         end
      endcase
   end

   // State, output and result-cache registers.
   always_ff @(posedge clk_i) begin
      if (clear_i) begin
         state_r       <= ST_IDLE;
         op_r          <= 3'b000;
         a_r           <= ZERO;
         b_r           <= ZERO;
         rd_r          <= 5'd0;
         wb_valid_r    <= 1'b0;
         wb_data_r     <= ZERO;
         strobe_r      <= 1'b0;
         ce_r          <= 1'b0;
         abort_r       <= 1'b0;
         guard_r       <= 1'b0;
         cache_valid_r <= 1'b0;
         cache_op_r    <= 3'b000;
         cache_a_r     <= ZERO;
         cache_b_r     <= ZERO;
         cache_res_r   <= ZERO;
      end else begin
         state_r    <= state_s;
         op_r       <= op_s;
         a_r        <= a_s;
         b_r        <= b_s;
         rd_r       <= rd_s;
         wb_valid_r <= wb_valid_s;
         wb_data_r  <= wb_data_s;
         strobe_r   <= strobe_s;
         ce_r       <= ce_s;
         abort_r    <= abort_s;
         guard_r    <= strobe_r;
         if (cache_we_s) begin
            cache_valid_r <= 1'b1;
            cache_op_r    <= op_r;
            cache_a_r     <= a_r;
            cache_b_r     <= b_r;
            cache_res_r   <= md_result_i;
         end else begin
            cache_valid_r <= cache_valid_r;
         end
      end
   end

   assign md_data_ready_o   = strobe_r;
   assign md_operation_o    = op_r;
   assign md_operand1_o     = a_r;
   assign md_operand2_o     = b_r;
   assign md_writeback_ce_o = ce_r;
   assign md_clear_o        = abort_r;
   assign wb_valid_o        = wb_valid_r;
   assign wb_rd_o           = rd_r;
   assign wb_data_o         = wb_data_r;

endmodule

// File: tb/tb_rv32im_muldiv_issue.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and
// randomized ops against an arithmetic reference model and a behavioural unit.
module tb_rv32im_muldiv_issue;
   import rv32im_muldiv_issue_pkg::*;

   logic        clk_i = 1'b0;
   logic        clear_i = 1'b1, flush_i = 1'b0, valid_i = 1'b0, wb_ready_i = 1'b0;
   logic        ready_o, md_data_ready_o, md_writeback_ce_o, md_clear_o, wb_valid_o;
   logic [2:0]  funct3_i = 3'b000, md_operation_o;
   logic [31:0] rs1_i = 32'd0, rs2_i = 32'd0, md_operand1_o, md_operand2_o, wb_data_o;
   logic [31:0] md_result_i;
   logic [4:0]  rd_i = 5'd0, wb_rd_o;
   logic        md_data_ready_i, md_busy_i, unit_busy = 1'b0, force_busy = 1'b0;

   int total = 0, bad = 0, strobe_cnt = 0, ce_cnt = 0, unit_lat = 33;
   logic        cv = 1'b0;
   logic [2:0]  c_op;
   logic [31:0] c_a, c_b;

   always #5 clk_i = ~clk_i;
   assign md_busy_i = unit_busy | force_busy;

   rv32im_muldiv_issue dut (
      .clk_i(clk_i), .clear_i(clear_i), .flush_i(flush_i), .valid_i(valid_i),
      .ready_o(ready_o), .funct3_i(funct3_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
      .md_data_ready_o(md_data_ready_o), .md_operation_o(md_operation_o),
      .md_operand1_o(md_operand1_o), .md_operand2_o(md_operand2_o),
      .md_writeback_ce_o(md_writeback_ce_o), .md_clear_o(md_clear_o),
      .md_result_i(md_result_i), .md_data_ready_i(md_data_ready_i), .md_busy_i(md_busy_i),
      .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o)
   );

   // RISC-V M-extension semantics from plain 64-bit arithmetic.
   function automatic logic [31:0] ref_md(logic [2:0] op, logic [31:0] a, logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      int ia, ib;
      sa = longint'($signed(a)); sb = longint'($signed(b));
      ua = longint'({32'h0, a}); ub = longint'({32'h0, b});
      ia = $signed(a); ib = $signed(b);
      case (op)
         3'b000: begin p = ua * ub; return p[31:0]; end
         3'b001: begin p = sa * sb; return p[63:32]; end
         3'b010: begin p = sa * ub; return p[63:32]; end
         3'b011: begin p = ua * ub; return p[63:32]; end
         3'b100: if (b == 32'd0) return 32'hFFFF_FFFF;
                 else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                 else return 32'(ia / ib);
         3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         3'b110: if (b == 32'd0) return a;
                 else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                 else return 32'(ia % ib);
         default: return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   function automatic logic answered_locally(logic [2:0] op, logic [31:0] a, logic [31:0] b);
      logic div_like, ovf;
      div_like = op[2];
      ovf = (op == 3'b100 || op == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
      return (div_like && b == 32'd0) || ovf;
   endfunction

   // Behavioural iterative unit: latches the strobe, computes after unit_lat cycles.
   initial begin
      logic [2:0]  u_op;
      logic [31:0] u_a, u_b;
      int cnt;
      md_data_ready_i = 1'b0; md_result_i = 32'd0; cnt = 0;
      forever begin
         @(posedge clk_i); #1;
         if (md_writeback_ce_o) ce_cnt++;
         if (md_clear_o || clear_i) begin
            unit_busy = 1'b0; md_data_ready_i = 1'b0;
         end else if (md_data_ready_o) begin
            strobe_cnt++;
            u_op = md_operation_o; u_a = md_operand1_o; u_b = md_operand2_o;
            unit_busy = 1'b1; md_data_ready_i = 1'b0; cnt = unit_lat;
         end else if (unit_busy) begin
            if (cnt <= 1) begin
               unit_busy = 1'b0; md_data_ready_i = 1'b1; md_result_i = ref_md(u_op, u_a, u_b);
            end else cnt--;
         end else if (md_writeback_ce_o) md_data_ready_i = 1'b0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, " ctl"}, {28'd0, wb_valid_o, md_data_ready_o, md_writeback_ce_o, md_clear_o}, 32'd0);
      chk({tag, " opnd"}, md_operand1_o | md_operand2_o | {29'd0, md_operation_o}, 32'd0);
      chk({tag, " wb"}, wb_data_o | {27'd0, wb_rd_o}, 32'd0);
      chk({tag, " ready"}, {31'd0, ready_o}, 32'd1);
   endtask

   task automatic present(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
      int w;
      w = 0;
      while (!ready_o && w < 200) begin @(posedge clk_i); #1; w++; end
      valid_i = 1'b1; funct3_i = op; rs1_i = a; rs2_i = b; rd_i = rd;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
   endtask

   task automatic check_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input int hold, input logic exp_valid,
                           input logic [31:0] exp_data, input logic exp_strobe, input string tag);
      int lat, s0, c0;
      logic gv;
      logic [31:0] gd;
      wb_ready_i = 1'b0;
      s0 = strobe_cnt; c0 = ce_cnt;
      present(op, a, b, rd);
      lat = 1;
      while (!wb_valid_o && !ready_o && lat < 300) begin @(posedge clk_i); #1; lat++; end
      gv = wb_valid_o; gd = wb_data_o;
      chk({tag, " valid"}, {31'd0, gv}, {31'd0, exp_valid});
      if (exp_valid) begin
         chk({tag, " data"}, gd, exp_data);
         chk({tag, " rd"}, {27'd0, wb_rd_o}, {27'd0, rd});
         if (!exp_strobe) chk({tag, " fast latency"}, 32'(lat), 32'd1);
         for (int i = 0; i < hold; i++) begin
            @(posedge clk_i); #1;
            chk({tag, " hold ctl"}, {30'd0, wb_valid_o, ready_o}, 32'd2);
            chk({tag, " hold data"}, wb_data_o, gd);
         end
         wb_ready_i = 1'b1;
         @(posedge clk_i); #1;
         wb_ready_i = 1'b0;
         chk({tag, " back to idle"}, {30'd0, wb_valid_o, ready_o}, 32'd1);
      end else begin
         chk({tag, " rd0 turnaround"}, 32'(lat), 32'd2);
      end
      #2;
      chk({tag, " strobes"}, 32'(strobe_cnt - s0), {31'd0, exp_strobe});
      chk({tag, " wb_ce"}, 32'(ce_cnt - c0), {31'd0, exp_strobe});
      if (exp_strobe) begin cv = 1'b1; c_op = op; c_a = a; c_b = b; end
   endtask

   // Model-driven expectation: unit used unless rd=x0, a corner case, or a repeat.
   task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input int hold, input string tag);
      logic hit, strobe;
      hit = cv && c_op == op && c_a == a && c_b == b;
      strobe = (rd != 5'd0) && !answered_locally(op, a, b) && !hit;
      check_op(op, a, b, rd, hold, rd != 5'd0, ref_md(op, a, b), strobe, tag);
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        exp_valid;
      logic [31:0] exp_data;
      logic        exp_strobe;
   } vec_t;

   vec_t vecs[16];

   initial begin
      int s0, c0, w;
      logic [2:0]  r_op;
      logic [31:0] r_a, r_b;
      logic [31:0] pool[8];
      vecs[0]  = '{3'b101, 32'd100,        32'd7,          5'd5,  1'b1, 32'd14,         1'b1};
      vecs[1]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd3,  1'b1, 32'h8000_0000,  1'b0};
      vecs[2]  = '{3'b111, 32'h1234,       32'd0,          5'd4,  1'b1, 32'h1234,       1'b0};
      vecs[3]  = '{3'b000, 32'd3,          32'd5,          5'd6,  1'b1, 32'd15,         1'b1};
      vecs[4]  = '{3'b000, 32'd3,          32'd5,          5'd7,  1'b1, 32'd15,         1'b0};
      vecs[5]  = '{3'b000, 32'd3,          32'd6,          5'd7,  1'b1, 32'd18,         1'b1};
      vecs[6]  = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd8,  1'b1, 32'd0,          1'b0};
      vecs[7]  = '{3'b100, 32'd7,          32'd0,          5'd9,  1'b1, 32'hFFFF_FFFF,  1'b0};
      vecs[8]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd10, 1'b1, 32'hFFFF_FFFE,  1'b1};
      vecs[9]  = '{3'b101, 32'd100,        32'd7,          5'd0,  1'b0, 32'd0,          1'b0};
      vecs[10] = '{3'b001, 32'hFFFF_FFFF,  32'd2,          5'd11, 1'b1, 32'hFFFF_FFFF,  1'b1};
      vecs[11] = '{3'b110, 32'hFFFF_FFF9,  32'd2,          5'd12, 1'b1, 32'hFFFF_FFFF,  1'b1};
      vecs[12] = '{3'b101, 32'd64,         32'd0,          5'd13, 1'b1, 32'hFFFF_FFFF,  1'b0};
      vecs[13] = '{3'b100, 32'hFFFF_FFF9,  32'd2,          5'd14, 1'b1, 32'hFFFF_FFFD,  1'b1};
      vecs[14] = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd15, 1'b1, 32'hFFFF_FFFF,  1'b1};
      vecs[15] = '{3'b111, 32'd100,        32'd7,          5'd16, 1'b1, 32'd2,          1'b1};

      repeat (3) @(posedge clk_i);
      #1 clear_i = 1'b0;
      chk_idle_zero("reset");

      for (int i = 0; i < 16; i++)
         check_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, (i == 0) ? 10 : 1,
                  vecs[i].exp_valid, vecs[i].exp_data, vecs[i].exp_strobe, $sformatf("vec%0d", i));

      // Flush while waiting on the unit.
      s0 = strobe_cnt; c0 = ce_cnt;
      present(3'b000, 32'd9, 32'd9, 5'd1);
      w = 0;
      while (!md_data_ready_o && w < 20) begin @(posedge clk_i); #1; w++; end
      chk("wait_flush strobe seen", {31'd0, md_data_ready_o}, 32'd1);
      @(posedge clk_i); #1;
      flush_i = 1'b1;
      @(posedge clk_i); #1;
      flush_i = 1'b0;
      chk("wait_flush md_clear", {29'd0, md_clear_o, ready_o, wb_valid_o}, 32'd6);
      @(posedge clk_i); #1;
      chk("wait_flush clear one cycle", {31'd0, md_clear_o}, 32'd0);
      w = 0;
      repeat (40) begin @(posedge clk_i); #1; if (wb_valid_o) w++; end
      chk("wait_flush no wb", 32'(w), 32'd0);
      chk("wait_flush counts", 32'((strobe_cnt - s0) * 16 + (ce_cnt - c0)), 32'd16);
      model_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0, "mulhu after flush");
      model_op(3'b000, 32'd9, 32'd9, 5'd1, 0, "aborted op not cached");

      // Flush in IDLE drops the request.
      s0 = strobe_cnt;
      valid_i = 1'b1; flush_i = 1'b1; funct3_i = 3'b101; rs1_i = 32'd77; rs2_i = 32'd3; rd_i = 5'd9;
      @(posedge clk_i); #1;
      valid_i = 1'b0; flush_i = 1'b0;
      repeat (4) @(posedge clk_i);
      #1;
      chk("idle_flush dropped", {30'd0, ready_o, wb_valid_o}, 32'd2);
      chk("idle_flush no strobe", 32'(strobe_cnt - s0), 32'd0);

      // Flush beats wb_ready in WB.
      present(3'b101, 32'd5, 32'd0, 5'd3);
      chk("wb_flush valid before", {31'd0, wb_valid_o}, 32'd1);
      flush_i = 1'b1; wb_ready_i = 1'b1;
      @(posedge clk_i); #1;
      flush_i = 1'b0; wb_ready_i = 1'b0;
      chk("wb_flush to idle", {30'd0, ready_o, wb_valid_o}, 32'd2);

      // Clear in ISSUE while the unit is busy, then a former cache hit must reissue.
      model_op(3'b000, 32'd11, 32'd13, 5'd4, 0, "pre-clear op");
      force_busy = 1'b1;
      present(3'b101, 32'd50, 32'd3, 5'd5);
      repeat (3) begin
         @(posedge clk_i); #1;
         chk("issue held busy", {30'd0, md_data_ready_o, ready_o}, 32'd0);
      end
      clear_i = 1'b1;
      @(posedge clk_i); #1;
      clear_i = 1'b0; force_busy = 1'b0;
      chk_idle_zero("clear in issue");
      cv = 1'b0;
      model_op(3'b000, 32'd11, 32'd13, 5'd4, 0, "reissue after clear");

      // Randomized ops, with repeats to exercise the result cache.
      pool = '{32'd0, 32'd1, 32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFF9, 32'd100, 32'd0};
      r_op = 3'b000; r_a = 32'd1; r_b = 32'd1;
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 3) != 0) begin
            r_op = 3'($urandom_range(0, 7));
            r_a = ($urandom_range(0, 2) == 0) ? $urandom : pool[$urandom_range(0, 6)];
            r_b = ($urandom_range(0, 2) == 0) ? $urandom : pool[$urandom_range(0, 6)];
         end
         unit_lat = $urandom_range(2, 12);
         model_op(r_op, r_a, r_b, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  $urandom_range(0, 3), $sformatf("rand%0d", n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
